// File: rtl/sm_add_arbiter.sv
// sm_add_arbiter: two requesters share one registered N-bit sign-magnitude adder, round-robin granted.
// Latency: request handshake in cycle t -> rsp_valid in cycle t+2; one transaction per 3 cycles minimum.
// Backpressure: readies are low until the response handshake completes; rsp_* held stable while rsp_ready=0.
// Optional build macro SM_ADD_ARBITER_OVF_EN adds rsp_ovf (lost magnitude carry on same-sign adds).
module sm_add_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_sum,
`ifdef SM_ADD_ARBITER_OVF_EN
   output logic         rsp_ovf,
`endif
   output logic         rsp_id
);

   localparam int M = N - 1;   // magnitude width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           ptr_q, ptr_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic           id_q, id_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [N-1:0]   rsp_sum_q, rsp_sum_d;
   logic           rsp_id_q, rsp_id_d;

   logic           win_vld;
   logic           win_id;
   logic [N-1:0]   sum_res;

   logic [M-1:0]   mag_a, mag_b, mag_r;
   logic           sgn_a, sgn_b, sgn_r;

`ifdef SM_ADD_ARBITER_OVF_EN
   logic           rsp_ovf_q, rsp_ovf_d;
   logic           ovf_res;
   logic [M:0]     mag_sum;
`endif

   // Winner selection: a lone requester wins outright, contention is settled by the pointer.
   always_comb begin
      win_vld = req0_valid | req1_valid;
      win_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
   end

   // Sign-magnitude add of the captured operands; equal magnitudes with opposite signs give +0.
   always_comb begin
      mag_a   = a_q[M-1:0];
      mag_b   = b_q[M-1:0];
      sgn_a   = a_q[N-1];
      sgn_b   = b_q[N-1];
      mag_r   = '0;
      sgn_r   = 1'b0;
`ifdef SM_ADD_ARBITER_OVF_EN
      mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
      ovf_res = 1'b0;
`endif
      if (sgn_a == sgn_b) begin
`ifdef SM_ADD_ARBITER_OVF_EN
         mag_r   = mag_sum[M-1:0];
         ovf_res = mag_sum[M];
`else
         mag_r   = mag_a + mag_b;
`endif
         sgn_r   = sgn_a;
      end else if (mag_a > mag_b) begin
         mag_r = mag_a - mag_b;
         sgn_r = sgn_a;
      end else if (mag_b > mag_a) begin
         mag_r = mag_b - mag_a;
         sgn_r = sgn_b;
      end else begin
         mag_r = '0;
         sgn_r = 1'b0;
      end
      sum_res = {sgn_r, mag_r};
   end

   // Next-state, grant and datapath control for the IDLE -> CALC -> RESP cycle.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_id_d    = rsp_id_q;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
`ifdef SM_ADD_ARBITER_OVF_EN
      rsp_ovf_d   = rsp_ovf_q;
`endif
      case (state_q)
         IDLE: begin
            req0_ready = req0_valid && !win_id;
            req1_ready = req1_valid &&  win_id;
            if (win_vld) begin
               a_d     = win_id ? req1_a : req0_a;
               b_d     = win_id ? req1_b : req0_b;
               id_d    = win_id;
               state_d = CALC;
            end
         end
         CALC: begin
            rsp_sum_d   = sum_res;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
`ifdef SM_ADD_ARBITER_OVF_EN
            rsp_ovf_d   = ovf_res;
`endif
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               ptr_d       = ~rsp_id_q;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_id_q    <= 1'b0;
`ifdef SM_ADD_ARBITER_OVF_EN
         rsp_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_id_q    <= rsp_id_d;
`ifdef SM_ADD_ARBITER_OVF_EN
         rsp_ovf_q   <= rsp_ovf_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
`ifdef SM_ADD_ARBITER_OVF_EN
   assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_sm_add_arbiter.sv
// tb_sm_add_arbiter: drives sm_add_arbiter with a cycle model and a result scoreboard.
// Expected results are pushed at each predicted grant and compared every cycle in RESP.
// Build with SM_ADD_ARBITER_OVF_EN to also check rsp_ovf.
module tb_sm_add_arbiter;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [N-1:0] rsp_sum;
   logic         rsp_id;
`ifdef SM_ADD_ARBITER_OVF_EN
   logic         rsp_ovf;
`endif

   always #5 clk = ~clk;

   sm_add_arbiter #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
`ifdef SM_ADD_ARBITER_OVF_EN
      .rsp_ovf    (rsp_ovf),
`endif
      .rsp_id     (rsp_id)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [N-1:0] sum;
      logic         id;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   logic gnt_log[$];
   bit   log_en   = 1'b0;
   bit   model_en = 1'b0;

   // Reference: evaluate as signed integers, then re-encode.
   function automatic exp_t ref_add(input logic id, input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      int ma, mb, va, vb, s;
      ma = int'(a[N-2:0]);
      mb = int'(b[N-2:0]);
      va = a[N-1] ? -ma : ma;
      vb = b[N-1] ? -mb : mb;
      e.id  = id;
      e.ovf = 1'b0;
      if (a[N-1] == b[N-1]) begin
         e.sum = {a[N-1], (N-1)'((ma + mb) % (1 << (N-1)))};
         e.ovf = ((ma + mb) >= (1 << (N-1)));
      end else begin
         s = va + vb;
         if (s == 0)     e.sum = '0;
         else if (s < 0) e.sum = {1'b1, (N-1)'(-s)};
         else            e.sum = {1'b0, (N-1)'(s)};
      end
      return e;
   endfunction

   typedef enum int {M_IDLE, M_CALC, M_RESP} mst_t;
   mst_t m_st = M_IDLE;
   mst_t m_nx = M_IDLE;
   logic m_ptr = 1'b0;

   // Cycle model, evaluated mid-cycle while inputs are stable.
   always @(negedge clk) begin
      logic w_id;
      exp_t e;
      m_st = m_nx;
      if (model_en) begin
         if (!rst_n) begin
            m_nx  = M_IDLE;
            m_ptr = 1'b0;
            sb.delete();
         end else begin
            chk("rdy_excl", {31'b0, req0_ready & req1_ready}, 32'd0);
            case (m_st)
               M_IDLE: begin
                  w_id = (req0_valid && req1_valid) ? m_ptr : req1_valid;
                  chk("vld_idle", {31'b0, rsp_valid}, 32'd0);
                  chk("rdy0", {31'b0, req0_ready}, {31'b0, req0_valid && !w_id});
                  chk("rdy1", {31'b0, req1_ready}, {31'b0, req1_valid && w_id});
                  if (req0_valid || req1_valid) begin
                     sb.push_back(ref_add(w_id, w_id ? req1_a : req0_a, w_id ? req1_b : req0_b));
                     if (log_en) gnt_log.push_back(w_id);
                     m_nx = M_CALC;
                  end
               end
               M_CALC: begin
                  chk("vld_calc", {31'b0, rsp_valid}, 32'd0);
                  chk("rdy_calc", {30'b0, req0_ready, req1_ready}, 32'd0);
                  m_nx = M_RESP;
               end
               default: begin
                  if (sb.size() == 0) begin
                     chk("sb_empty", 32'd1, 32'd0);
                     m_nx = M_IDLE;
                  end else begin
                     e = sb[0];
                     chk("vld_resp", {31'b0, rsp_valid}, 32'd1);
                     chk("sum", {28'b0, rsp_sum}, {28'b0, e.sum});
                     chk("id", {31'b0, rsp_id}, {31'b0, e.id});
`ifdef SM_ADD_ARBITER_OVF_EN
                     chk("ovf", {31'b0, rsp_ovf}, {31'b0, e.ovf});
`endif
                     chk("rdy_resp", {30'b0, req0_ready, req1_ready}, 32'd0);
                     if (rsp_ready) begin
                        void'(sb.pop_front());
                        m_ptr = ~e.id;
                        m_nx  = M_IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic id, input logic [N-1:0] a, input logic [N-1:0] b);
      bit got;
      got = 1'b0;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) got = 1'b1;
         tick();
      end
      if (!got) chk("hs_timeout", 32'd0, 32'd1);
      // scramble operands after the handshake; the result must not change
      if (id) begin req1_valid = 1'b0; req1_a = N'($urandom); req1_b = N'($urandom); end
      else    begin req0_valid = 1'b0; req0_a = N'($urandom); req0_b = N'($urandom); end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (m_nx == M_IDLE && sb.size() == 0) done = 1'b1;
      end
      if (!done) chk("idle_timeout", 32'd0, 32'd1);
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) tick();
      model_en = 1'b1;
      do_reset();
      @(negedge clk);
      chk("rst_vld", {31'b0, rsp_valid}, 32'd0);
      chk("rst_sum", {28'b0, rsp_sum}, 32'd0);
      chk("rst_id", {31'b0, rsp_id}, 32'd0);
      chk("rst_rdy", {30'b0, req0_ready, req1_ready}, 32'd0);
`ifdef SM_ADD_ARBITER_OVF_EN
      chk("rst_ovf", {31'b0, rsp_ovf}, 32'd0);
`endif
      tick();

      // directed cases
      send(1'b0, 4'b0011, 4'b0010); wait_idle();
      send(1'b1, 4'b0011, 4'b1101); wait_idle();
      send(1'b0, 4'b0101, 4'b1101); wait_idle();
      send(1'b0, 4'b0111, 4'b0001); wait_idle();
      send(1'b0, 4'b0011, 4'b0001); wait_idle();
      send(1'b1, 4'b1000, 4'b1000); wait_idle();
      send(1'b1, 4'b1110, 4'b0010); wait_idle();

      // random cases
      for (int i = 0; i < 16; i++) begin
         send(1'($urandom), N'($urandom), N'($urandom));
         wait_idle();
      end

      // round robin under continuous contention, from reset
      do_reset();
      gnt_log.delete();
      log_en = 1'b1;
      req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0010;
      req1_valid = 1'b1; req1_a = 4'b1011; req1_b = 4'b0001;
      repeat (12) tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();
      log_en = 1'b0;
      chk("rr_cnt_ge4", {31'b0, gnt_log.size() >= 4}, 32'd1);
      if (gnt_log.size() >= 4) begin
         chk("rr_g0", {31'b0, gnt_log[0]}, 32'd0);
         chk("rr_g1", {31'b0, gnt_log[1]}, 32'd1);
         chk("rr_g2", {31'b0, gnt_log[2]}, 32'd0);
         chk("rr_g3", {31'b0, gnt_log[3]}, 32'd1);
      end

      // backpressure: hold the response 5 cycles with a competing request pending
      rsp_ready = 1'b0;
      send(1'b1, 4'b0110, 4'b1010);
      tick();
      req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001;
      repeat (5) tick();
      req0_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();

      // reset while in CALC: pointer would otherwise favour requester 1
      send(1'b0, 4'b0001, 4'b0001); wait_idle();
      send(1'b0, 4'b0010, 4'b0011);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_vld", {31'b0, rsp_valid}, 32'd0);
      tick();
      gnt_log.delete();
      log_en = 1'b1;
      req0_valid = 1'b1; req0_a = 4'b0100; req0_b = 4'b1001;
      req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b0010;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();
      log_en = 1'b0;
      chk("abort_cnt", gnt_log.size(), 32'd1);
      if (gnt_log.size() >= 1) chk("abort_ptr", {31'b0, gnt_log[0]}, 32'd0);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
